// File: rtl/dma_xfer_seq.sv
// dma_xfer_seq: REU DMA sequencer that owns the C64 address, REU address and
// length counters, honours BA stalls, and handles the C64->REU, REU->C64, swap
// and verify transfer types with fixed-address modes and verify abort.
// State advances on the falling edge of PHI2. RESET is synchronous and active-high.
// Optional feature macro: DMASEQ_AUTOLOAD_EN enables counter reload at the end of a transfer.
module dma_xfer_seq #(
  parameter int unsigned CA_W  = 16,
  parameter int unsigned RA_W  = 24,
  parameter int unsigned LEN_W = 16
) (
  input  logic             PHI2,
  input  logic             RESET,
  input  logic             BA,
  input  logic             Execute,
  input  logic [1:0]       XferType,
  input  logic             FixCA,
  input  logic             FixRA,
  input  logic             Autoload,
  input  logic [CA_W-1:0]  CAStart,
  input  logic [RA_W-1:0]  RAStart,
  input  logic [LEN_W-1:0] LenStart,
  input  logic             Equal,
  output logic             DMA,
  output logic             DMARW,
  output logic             RAMRD,
  output logic             RAMWR,
  output logic [CA_W-1:0]  CA,
  output logic [RA_W-1:0]  REUA,
  output logic [LEN_W-1:0] Len,
  output logic             Busy,
  output logic             XferEnd,
  output logic             VerifyErr
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_XFER  = 2'b01,
    ST_FLUSH = 2'b10
  } state_e;

  typedef enum logic [1:0] {
    XT_C2R    = 2'b00,
    XT_R2C    = 2'b01,
    XT_SWAP   = 2'b10,
    XT_VERIFY = 2'b11
  } xfer_e;

  state_e           state_q;
  xfer_e            type_q;
  logic             fix_ca_q;
  logic             fix_ra_q;
  logic             phase_b_q;
  logic             first_q;
  logic [CA_W-1:0]  ca_q;
  logic [RA_W-1:0]  ra_q;
  logic [LEN_W-1:0] len_q;
  logic             dma_q;
  logic             dmarw_q;
  logic             ramrd_q;
  logic             ramwr_q;
  logic             xend_q;
  logic             verr_q;

  logic             advance_c;
  logic             mismatch_c;
  logic             terminal_c;
  logic [CA_W-1:0]  ca_d;
  logic [RA_W-1:0]  ra_d;
  logic [LEN_W-1:0] len_d;

`ifdef DMASEQ_AUTOLOAD_EN
  logic             autoload_q;
  logic [CA_W-1:0]  ca_start_q;
  logic [RA_W-1:0]  ra_start_q;
  logic [LEN_W-1:0] len_start_q;
`else
  logic             unused_autoload;
  assign unused_autoload = Autoload;
`endif

  // Bus-cycle decode: whether this edge advances the counters and whether it ends the transfer
  always_comb begin
    advance_c  = 1'b0;
    mismatch_c = 1'b0;
    if (state_q == ST_XFER && BA) begin
      advance_c  = (type_q != XT_SWAP) || phase_b_q;
      mismatch_c = (type_q == XT_VERIFY) && !Equal;
    end
    terminal_c = advance_c && ((len_q == LEN_W'(1)) || mismatch_c);
    ca_d  = fix_ca_q ? ca_q : ca_q + CA_W'(1);
    ra_d  = fix_ra_q ? ra_q : ra_q + RA_W'(1);
    // the final length stays at 1; a verify abort still consumes the mismatching byte
    len_d = (len_q == LEN_W'(1)) ? len_q : len_q - LEN_W'(1);
  end

  // Sequencer state, counters and registered bus/SDRAM command outputs
  always_ff @(negedge PHI2) begin
    if (RESET) begin
      state_q   <= ST_IDLE;
      type_q    <= XT_C2R;
      fix_ca_q  <= 1'b0;
      fix_ra_q  <= 1'b0;
      phase_b_q <= 1'b0;
      first_q   <= 1'b0;
      dma_q     <= 1'b0;
      dmarw_q   <= 1'b0;
      ramrd_q   <= 1'b0;
      ramwr_q   <= 1'b0;
      xend_q    <= 1'b0;
      verr_q    <= 1'b0;
`ifdef DMASEQ_AUTOLOAD_EN
      autoload_q <= 1'b0;
      // an aborted autoload transfer leaves the register file start values in place
      if (autoload_q && state_q != ST_IDLE) begin
        ca_q  <= ca_start_q;
        ra_q  <= ra_start_q;
        len_q <= len_start_q;
      end else begin
        ca_q  <= '0;
        ra_q  <= '0;
        len_q <= '0;
      end
`else
      ca_q      <= '0;
      ra_q      <= '0;
      len_q     <= '0;
`endif
    end else begin
      ramrd_q <= 1'b0;
      ramwr_q <= 1'b0;
      xend_q  <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          dma_q   <= 1'b0;
          dmarw_q <= 1'b0;
          if (Execute) begin
            ca_q      <= CAStart;
            ra_q      <= RAStart;
            len_q     <= LenStart;
            type_q    <= xfer_e'(XferType);
            fix_ca_q  <= FixCA;
            fix_ra_q  <= FixRA;
            phase_b_q <= 1'b0;
            first_q   <= 1'b1;
            verr_q    <= 1'b0;
            dma_q     <= 1'b1;
            state_q   <= ST_XFER;
`ifdef DMASEQ_AUTOLOAD_EN
            autoload_q  <= Autoload;
            ca_start_q  <= CAStart;
            ra_start_q  <= RAStart;
            len_start_q <= LenStart;
`endif
          end
        end
        ST_XFER: begin
          if (BA) begin
            case (type_q)
              XT_C2R: begin
                // each write stores the byte fetched on the previous bus cycle
                dmarw_q <= 1'b1;
                ramwr_q <= !first_q;
              end
              XT_R2C: begin
                dmarw_q <= 1'b0;
                ramrd_q <= 1'b1;
              end
              XT_SWAP: begin
                dmarw_q   <= !phase_b_q;
                ramrd_q   <= !phase_b_q;
                ramwr_q   <= phase_b_q;
                phase_b_q <= !phase_b_q;
              end
              default: begin
                dmarw_q <= 1'b1;
                ramrd_q <= 1'b1;
                if (mismatch_c) verr_q <= 1'b1;
              end
            endcase
            first_q <= 1'b0;
            if (advance_c) begin
              ca_q  <= ca_d;
              ra_q  <= ra_d;
              len_q <= len_d;
            end
            if (terminal_c) begin
              xend_q  <= 1'b1;
              dma_q   <= 1'b0;
              state_q <= (type_q == XT_C2R) ? ST_FLUSH : ST_IDLE;
`ifdef DMASEQ_AUTOLOAD_EN
              if (autoload_q) begin
                ca_q  <= ca_start_q;
                ra_q  <= ra_start_q;
                len_q <= len_start_q;
              end
`endif
            end
          end
        end
        ST_FLUSH: begin
          // write the last byte read from the C64 after releasing the bus
          dma_q   <= 1'b0;
          dmarw_q <= 1'b0;
          ramwr_q <= 1'b1;
          state_q <= ST_IDLE;
        end
        default: begin
          dma_q   <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign DMA       = dma_q;
  assign DMARW     = dmarw_q;
  assign RAMRD     = ramrd_q;
  assign RAMWR     = ramwr_q;
  assign CA        = ca_q;
  assign REUA      = ra_q;
  assign Len       = len_q;
  assign Busy      = (state_q != ST_IDLE);
  assign XferEnd   = xend_q;
  assign VerifyErr = verr_q;

endmodule

// File: tb/tb_dma_xfer_seq.sv
// tb_dma_xfer_seq: randomized bench for dma_xfer_seq against a byte-level transfer model.
module tb_dma_xfer_seq;
  localparam int unsigned CA_W  = 16;
  localparam int unsigned RA_W  = 24;
  localparam int unsigned LEN_W = 16;
  localparam int unsigned OW    = 6 + CA_W + RA_W + LEN_W;

  logic             PHI2;
  logic             RESET;
  logic             BA;
  logic             Execute;
  logic [1:0]       XferType;
  logic             FixCA;
  logic             FixRA;
  logic             Autoload;
  logic [CA_W-1:0]  CAStart;
  logic [RA_W-1:0]  RAStart;
  logic [LEN_W-1:0] LenStart;
  logic             Equal;
  logic             DMA;
  logic             DMARW;
  logic             RAMRD;
  logic             RAMWR;
  logic [CA_W-1:0]  CA;
  logic [RA_W-1:0]  REUA;
  logic [LEN_W-1:0] Len;
  logic             Busy;
  logic             XferEnd;
  logic             VerifyErr;

  int total;
  int bad;

  dma_xfer_seq #(.CA_W(CA_W), .RA_W(RA_W), .LEN_W(LEN_W)) dut (
    .PHI2(PHI2), .RESET(RESET), .BA(BA), .Execute(Execute), .XferType(XferType),
    .FixCA(FixCA), .FixRA(FixRA), .Autoload(Autoload), .CAStart(CAStart),
    .RAStart(RAStart), .LenStart(LenStart), .Equal(Equal), .DMA(DMA), .DMARW(DMARW),
    .RAMRD(RAMRD), .RAMWR(RAMWR), .CA(CA), .REUA(REUA), .Len(Len), .Busy(Busy),
    .XferEnd(XferEnd), .VerifyErr(VerifyErr)
  );

  // DUT updates on negedge; the bench drives and samples on posedge
  initial begin
    PHI2 = 1'b1;
    forever #5 PHI2 = ~PHI2;
  end

  function automatic logic [OW-1:0] pack(input bit dma, input bit rd, input bit wr,
                                         input bit xe, input bit busy, input bit ve,
                                         input int ca, input int ra, input int len);
    return {dma, rd, wr, xe, busy, ve, CA_W'(ca), RA_W'(ra), LEN_W'(len)};
  endfunction

  function automatic logic [OW-1:0] obs();
    return {DMA, RAMRD, RAMWR, XferEnd, Busy, VerifyErr, CA, REUA, Len};
  endfunction

  // One complete transfer: ty 0=C64->REU 1=REU->C64 2=swap 3=verify; mis = byte index of verify mismatch
  task automatic run_xfer(input string name, input int ty, input bit fca, input bit fra,
                          input int cs, input int rs, input int ls, input int mis,
                          input int unsigned ba_pct);
    int n, k, cyc, e_ca, e_ra, e_len;
    bit half, done, ba, eq, adv, last, verr, rd, wr, rw;
    logic [OW-1:0] exp_v, got;
    n = (ls == 0) ? 65536 : ls;
    @(posedge PHI2);
    XferType = 2'(ty); FixCA = fca; FixRA = fra;
    CAStart = CA_W'(cs); RAStart = RA_W'(rs); LenStart = LEN_W'(ls);
    Execute = 1'b1; BA = 1'($urandom); Equal = 1'($urandom); Autoload = 1'($urandom);
    @(posedge PHI2);
    Execute = 1'b0;
    got = obs(); exp_v = pack(1, 0, 0, 0, 1, 0, cs, rs, ls);
    total++;
    if (got !== exp_v) begin
      bad++; $display("FAIL %s start: got %h exp %h", name, got, exp_v);
    end
    k = 0; cyc = 0; half = 0; verr = 0; done = 0;
    e_ca = cs; e_ra = rs; e_len = ls;
    while (!done) begin
      ba = ($urandom_range(99) < ba_pct);
      eq = !(ty == 3 && k == mis);
      BA = ba; Equal = eq;
      // activity on the start/command inputs while busy must be ignored
      Execute = 1'($urandom); CAStart = CA_W'($urandom); RAStart = RA_W'($urandom);
      LenStart = LEN_W'($urandom); XferType = 2'($urandom);
      FixCA = 1'($urandom); FixRA = 1'($urandom);
      @(posedge PHI2);
      cyc++;
      rd = 0; wr = 0; rw = 0; adv = 0; last = 0;
      if (ba) begin
        case (ty)
          0: begin rw = 1; wr = (k > 0); adv = 1; end
          1: begin rd = 1; adv = 1; end
          2: begin
            if (!half) begin rw = 1; rd = 1; end
            else begin wr = 1; adv = 1; end
            half = !half;
          end
          default: begin rw = 1; rd = 1; adv = 1; if (!eq) verr = 1; end
        endcase
        if (adv) begin
          k++;
          last = (k == n) || !eq;
        end
      end
      e_ca  = fca ? cs : cs + k;
      e_ra  = fra ? rs : rs + k;
      e_len = (k == n) ? 1 : ls - k;
      got = obs();
      exp_v = pack(!last, rd, wr, last, !last || ty == 0, verr, e_ca, e_ra, e_len);
      total++;
      if (got !== exp_v) begin
        bad++; $display("FAIL %s cycle %0d: got %h exp %h", name, cyc, got, exp_v);
      end
      if (ba) begin
        total++;
        if (DMARW !== rw) begin
          bad++; $display("FAIL %s dmarw cycle %0d: got %b exp %b", name, cyc, DMARW, rw);
        end
      end
      if (last) done = 1;
      if (cyc > 4 * n + 100) begin
        total++; bad++;
        $display("FAIL %s timeout: got no end after %0d cycles exp %0d bytes", name, cyc, n);
        done = 1;
      end
    end
    Execute = 1'b0; BA = 1'($urandom);
    if (ty == 0) begin
      @(posedge PHI2);
      got = obs(); exp_v = pack(0, 0, 1, 0, 0, verr, e_ca, e_ra, e_len);
      total++;
      if (got !== exp_v) begin
        bad++; $display("FAIL %s flush: got %h exp %h", name, got, exp_v);
      end
    end
    @(posedge PHI2);
    got = obs(); exp_v = pack(0, 0, 0, 0, 0, verr, e_ca, e_ra, e_len);
    total++;
    if (got !== exp_v || DMARW !== 1'b0) begin
      bad++; $display("FAIL %s idle: got %h/%b exp %h/0", name, got, DMARW, exp_v);
    end
  endtask

  task automatic test_reset();
    logic [OW-1:0] got;
    RESET = 1'b1; BA = 1'b0; Execute = 1'b0; XferType = 2'b00; FixCA = 1'b0; FixRA = 1'b0;
    Autoload = 1'b0; CAStart = '0; RAStart = '0; LenStart = '0; Equal = 1'b1;
    repeat (2) @(posedge PHI2);
    got = obs();
    total++;
    if (got !== '0 || DMARW !== 1'b0) begin
      bad++; $display("FAIL reset: got %h/%b exp 0/0", got, DMARW);
    end
    RESET = 1'b0;
  endtask

  task automatic test_reu_to_c64();
    run_xfer("r2c_dir", 1, 0, 0, 'h1000, 'h10, 3, -1, 100);
    for (int i = 0; i < 4; i++)
      run_xfer("r2c_rnd", 1, 1'($urandom), 1'($urandom), int'($urandom_range(16'hFFFF)),
               int'($urandom_range(24'hFFFFFF)), int'($urandom_range(6, 1)), -1, 60);
  endtask

  task automatic test_c64_to_reu();
    run_xfer("c2r_dir", 0, 0, 0, 'h2000, 'h100, 2, -1, 100);
    run_xfer("c2r_one", 0, 0, 0, 'hFFFF, 'hFFFFFF, 1, -1, 100);
    for (int i = 0; i < 4; i++)
      run_xfer("c2r_rnd", 0, 1'($urandom), 1'($urandom), int'($urandom_range(16'hFFFF)),
               int'($urandom_range(24'hFFFFFF)), int'($urandom_range(6, 1)), -1, 60);
  endtask

  task automatic test_swap();
    run_xfer("swap_dir", 2, 0, 0, 'h3000, 'h40, 2, -1, 100);
    for (int i = 0; i < 4; i++)
      run_xfer("swap_rnd", 2, 1'($urandom), 1'($urandom), int'($urandom_range(16'hFFFF)),
               int'($urandom_range(24'hFFFFFF)), int'($urandom_range(5, 1)), -1, 50);
  endtask

  task automatic test_verify();
    run_xfer("vfy_abort", 3, 0, 0, 'h4000, 'h800, 8, 2, 100);
    run_xfer("vfy_clean", 3, 0, 0, 'h4000, 'h800, 4, 9, 70);
    run_xfer("vfy_lastbyte", 3, 0, 0, 'h5000, 'h900, 3, 2, 70);
    for (int i = 0; i < 4; i++) begin
      int l;
      l = int'($urandom_range(6, 1));
      run_xfer("vfy_rnd", 3, 1'($urandom), 1'($urandom), int'($urandom_range(16'hFFFF)),
               int'($urandom_range(24'hFFFFFF)), l, int'($urandom_range(l, 0)), 70);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 30; i++) begin
      int ty, l;
      ty = int'($urandom_range(3));
      l  = int'($urandom_range(6, 1));
      run_xfer("mixed", ty, 1'($urandom), 1'($urandom), int'($urandom_range(16'hFFFF)),
               int'($urandom_range(24'hFFFFFF)), l, int'($urandom_range(l, 0)),
               $urandom_range(100, 40));
    end
  endtask

  task automatic test_wrap_full_length();
    run_xfer("wrap64k", 1, 0, 1, 'hFFF0, 'hFFFFFF, 0, -1, 100);
  endtask

  task automatic test_reset_mid();
    logic [OW-1:0] got;
    @(posedge PHI2);
    XferType = 2'b00; FixCA = 1'b0; FixRA = 1'b0; CAStart = 16'h6000; RAStart = 24'h1234;
    LenStart = 16'd6; BA = 1'b1; Execute = 1'b1;
    @(posedge PHI2);
    Execute = 1'b0;
    repeat (3) @(posedge PHI2);
    RESET = 1'b1;
    @(posedge PHI2);
    got = obs();
    total++;
    if (got !== '0 || DMARW !== 1'b0) begin
      bad++; $display("FAIL reset_mid: got %h/%b exp 0/0", got, DMARW);
    end
    RESET = 1'b0;
    @(posedge PHI2);
    got = obs();
    total++;
    if (got !== '0) begin
      bad++; $display("FAIL reset_mid_noflush: got %h exp 0", got);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_reu_to_c64();
    test_c64_to_reu();
    test_swap();
    test_verify();
    test_random();
    test_reset_mid();
    test_wrap_full_length();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
